// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared constants and types for the EX-stage hazard sequencer.
package ex_hazard_ctrl_pkg;

  // Opcode/funct constants shared with EX and the decoder
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [5:0] FUNCT_MUL   = 6'b000010;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } hz_state_e;

  // Load-use: the load in EX writes a register the ID instruction reads.
  // r0 is hard-wired zero, so a load into r0 never creates a dependency.
  function automatic logic is_load_use(
    input logic       id_valid,
    input logic [4:0] id_rs_addr,
    input logic [4:0] id_rt_addr,
    input logic       id_uses_rt,
    input logic       ex_mem_read,
    input logic [4:0] ex_rd
  );
    return id_valid && ex_mem_read && (ex_rd != 5'd0) &&
           ((ex_rd == id_rs_addr) || (id_uses_rt && (ex_rd == id_rt_addr)));
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard sequencer: MUL stall, load-use bubble, taken-branch squash.
// Handshake note: there is no valid/ready pair here; pc_write_en and
// ifid_write_en act as the "ready" of the front end, sampled every rising edge.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT      = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mul_valid,
  input  logic        ex_branch_taken,
  output logic        stall_flag,
  output logic        pc_write_en,
  output logic        ifid_write_en,
  output logic        idex_bubble,
  output logic        squash,
  output logic        busy,
  output logic [15:0] stall_cycles
);

  localparam logic [CNT_W-1:0] MUL_CNT_INIT   = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] FLUSH_CNT_INIT = CNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  hz_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;

  assign load_use = is_load_use(id_valid, id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_read, ex_rd);
  assign busy     = (state != ST_IDLE);

  // State and down-counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and Mealy controls; outputs forced to pass values while reset is high
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    stall_flag    = 1'b0;
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    idex_bubble   = 1'b0;
    squash        = 1'b0;
    if (!reset) begin
      unique case (state)
        ST_IDLE: begin
          if (ex_branch_taken) begin
            squash      = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = ST_FLUSH;
              cnt_nxt   = FLUSH_CNT_INIT;
            end
          end else if (ex_mul_valid && (MUL_LAT > 1)) begin
            stall_flag    = 1'b1;
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            state_nxt     = ST_MUL_WAIT;
            cnt_nxt       = MUL_CNT_INIT;
          end else if (load_use) begin
            // Load proceeds to MEM; next cycle the hazard is gone
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
          end
        end
        ST_MUL_WAIT: begin
          if (cnt != '0) begin
            stall_flag    = 1'b1;
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            cnt_nxt       = cnt - CNT_W'(1);
          end else begin
            // Release cycle: MUL result leaves EX
            state_nxt = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          squash      = 1'b1;
          idex_bubble = 1'b1;
          if (cnt == '0) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (~pc_write_en),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl (MUL_LAT=4, FLUSH_CYCLES=2).
module tb_ex_hazard_ctrl;

  localparam int MUL_LAT      = 4;
  localparam int FLUSH_CYCLES = 2;

  // Output frame bits: {stall_flag, pc_write_en, ifid_write_en, idex_bubble, squash}
  localparam logic [4:0] FR_PASS  = 5'b01100;
  localparam logic [4:0] FR_STALL = 5'b10000;
  localparam logic [4:0] FR_SQ    = 5'b01111;
  localparam logic [4:0] FR_LU    = 5'b00010;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rt, ex_mem_read, ex_mul_valid, ex_branch_taken;
  logic [4:0]  id_rs_addr, id_rt_addr, ex_rd;
  logic        stall_flag, pc_write_en, ifid_write_en, idex_bubble, squash, busy;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Reference: a schedule of pre-committed future frames; empty means free to react
  logic [4:0] exp_q[$];
  int         exp_cnt;

  // Clock
  always #5 clk = ~clk;

  ex_hazard_ctrl #(.MUL_LAT(MUL_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_mul_valid(ex_mul_valid), .ex_branch_taken(ex_branch_taken),
    .stall_flag(stall_flag), .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .idex_bubble(idex_bubble), .squash(squash), .busy(busy), .stall_cycles(stall_cycles)
  );

  function automatic logic [4:0] outs();
    return {stall_flag, pc_write_en, ifid_write_en, idex_bubble, squash};
  endfunction

  function automatic logic model_lu();
    return id_valid && ex_mem_read && (ex_rd != 5'd0) &&
           ((ex_rd == id_rs_addr) || (id_uses_rt && (ex_rd == id_rt_addr)));
  endfunction

  function automatic logic [4:0] model_frame();
    if (exp_q.size() != 0)                 return exp_q[0];
    if (ex_branch_taken)                   return FR_SQ;
    if (ex_mul_valid && (MUL_LAT > 1))     return FR_STALL;
    if (model_lu())                        return FR_LU;
    return FR_PASS;
  endfunction

  task automatic model_commit(input logic [4:0] f);
    if (!f[3] && exp_cnt < 65535) exp_cnt++;
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (ex_branch_taken) begin
      for (int i = 0; i < FLUSH_CYCLES - 1; i++) exp_q.push_back(FR_SQ);
    end else if (ex_mul_valid && (MUL_LAT > 1)) begin
      for (int i = 0; i < MUL_LAT - 2; i++) exp_q.push_back(FR_STALL);
      exp_q.push_back(FR_PASS);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    id_valid = 1'b0; id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; ex_mul_valid = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    id_valid = 1'b1; id_rs_addr = 5'd5; id_rt_addr = 5'd9; id_uses_rt = 1'b0;
    ex_mem_read = 1'b1; ex_rd = rd;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit(model_frame());
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    checks++;
    if (outs() !== FR_PASS || busy !== 1'b0 || stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: got outs=%b busy=%b cnt=%0d, want outs=%b busy=0 cnt=0",
               outs(), busy, stall_cycles, FR_PASS);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load_use(5'd5);
    sample();
    checks++;
    if (outs() !== FR_LU || outs() !== model_frame()) begin
      errors++;
      $display("FAIL load_use: got %b want %b", outs(), FR_LU);
    end
    tick();
    idle_inputs();
    sample();
    checks++;
    if (outs() !== FR_PASS || stall_cycles !== 16'd1) begin
      errors++;
      $display("FAIL load_use_after: got outs=%b cnt=%0d want outs=%b cnt=1", outs(), stall_cycles, FR_PASS);
    end
    tick();
    set_load_use(5'd0);
    ex_rd = 5'd0; id_rs_addr = 5'd0;
    sample();
    checks++;
    if (outs() !== FR_PASS) begin
      errors++;
      $display("FAIL load_use_r0: got %b want %b", outs(), FR_PASS);
    end
    tick();
    set_load_use(5'd7);
    id_uses_rt = 1'b1; id_rt_addr = 5'd7;
    sample();
    checks++;
    if (outs() !== FR_LU) begin
      errors++;
      $display("FAIL load_use_rt: got %b want %b", outs(), FR_LU);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_mul();
    logic [3:0] want_stall, want_busy;
    want_stall = 4'b1110;
    want_busy  = 4'b0111;
    apply_reset();
    ex_mul_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      checks++;
      if (stall_flag !== want_stall[3-i] || busy !== want_busy[3-i] ||
          pc_write_en !== ~want_stall[3-i]) begin
        errors++;
        $display("FAIL mul_cycle%0d: got stall=%b busy=%b pc=%b want stall=%b busy=%b",
                 i, stall_flag, busy, pc_write_en, want_stall[3-i], want_busy[3-i]);
      end
      tick();
    end
    ex_mul_valid = 1'b0;
    sample();
    checks++;
    if (stall_cycles !== 16'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_count: got cnt=%0d busy=%b want cnt=3 busy=0", stall_cycles, busy);
    end
    tick();
  endtask

  task automatic test_branch();
    logic [2:0] want_sq;
    want_sq = 3'b110;
    apply_reset();
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++;
      if (squash !== want_sq[2-i] || idex_bubble !== want_sq[2-i] || pc_write_en !== 1'b1 ||
          busy !== (i == 1)) begin
        errors++;
        $display("FAIL branch_cycle%0d: got sq=%b bub=%b pc=%b busy=%b want sq=%b pc=1",
                 i, squash, idex_bubble, pc_write_en, busy, want_sq[2-i]);
      end
      tick();
      ex_branch_taken = 1'b0;
    end
  endtask

  task automatic test_priority();
    apply_reset();
    set_load_use(5'd5);
    ex_branch_taken = 1'b1;
    ex_mul_valid = 1'b1;
    sample();
    checks++;
    if (outs() !== FR_SQ) begin
      errors++;
      $display("FAIL prio_branch: got %b want %b", outs(), FR_SQ);
    end
    tick();
    idle_inputs();
    tick();
    ex_mul_valid = 1'b1;
    tick();
    ex_mul_valid = 1'b0;
    set_load_use(5'd5);
    for (int i = 0; i < 4; i++) begin
      sample();
      checks++;
      if (outs() !== ((i < 2) ? FR_STALL : (i == 2) ? FR_PASS : FR_LU)) begin
        errors++;
        $display("FAIL prio_mul_lu%0d: got %b want %b", i, outs(),
                 (i < 2) ? FR_STALL : (i == 2) ? FR_PASS : FR_LU);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_mul();
    apply_reset();
    ex_mul_valid = 1'b1;
    tick();
    tick();
    ex_mul_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    checks++;
    if (outs() !== FR_PASS || busy !== 1'b0 || stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_mul: got outs=%b busy=%b cnt=%0d want %b 0 0", outs(), busy, stall_cycles, FR_PASS);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    sample();
    checks++;
    if (stall_flag !== 1'b0 || busy !== 1'b0 || squash !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got stall=%b busy=%b sq=%b want 0 0 0", stall_flag, busy, squash);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] f;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      id_valid        = ($urandom_range(0, 3) != 0);
      id_rs_addr      = 5'($urandom_range(0, 3));
      id_rt_addr      = 5'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_rd           = 5'($urandom_range(0, 3));
      ex_mul_valid    = ($urandom_range(0, 7) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      sample();
      f = model_frame();
      checks++;
      if (outs() !== f || busy !== (exp_q.size() != 0) || stall_cycles !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL random_%0d: got outs=%b busy=%b cnt=%0d want outs=%b busy=%b cnt=%0d",
                 n, outs(), busy, stall_cycles, f, (exp_q.size() != 0), exp_cnt);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    apply_reset();
    set_load_use(5'd5);
    for (int n = 0; n < 66000; n++) tick();
    idle_inputs();
    sample();
    checks++;
    if (stall_cycles !== 16'hFFFF || exp_cnt != 65535) begin
      errors++;
      $display("FAIL saturation: got %h want ffff (model %0d)", stall_cycles, exp_cnt);
    end
    tick();
  endtask

  // Test sequence and final report
  initial begin
    reset = 1'b1;
    exp_cnt = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_load_use();
    test_mul();
    test_branch();
    test_priority();
    test_reset_mid_mul();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
